digital_clock: RTL and testbench

- Time-of-day counter for the watch chip; the module is named digital_clock.
- It keeps seconds, minutes and hours from a 1 Hz tick clock; each rising edge of Clk_1sec is one second.
- Has a run mode (clock_enable=1) and a set mode (clock_enable=0); in set mode the time is frozen and minute/hour push-buttons adjust it.
- Sits between the 1 Hz prescaler and the display/encoding logic.

---
 rtl/digital_clock.sv | 160 ++++++++++++++++
 tb/tb_digital_clock.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/digital_clock.sv
// digital_clock: time-of-day counter driven by a 1 Hz tick clock.
// Run mode (clock_enable=1) counts seconds/minutes/hours with carries.
// Set mode (clock_enable=0) freezes the count. In this mode, rising edges of the
// minute/hour buttons step the matching field up or down, wrapping at each end.
// Optional feature macro: DIGITAL_CLOCK_AM_PM_EN adds a pm output and turns
// the hours output into a 12-hour display (1..12).
`timescale 1ns/1ps
module digital_clock #(
    parameter int HOURS_PER_DAY      = 24,
    parameter int MINUTES_PER_HOUR   = 60,
    parameter int SECONDS_PER_MINUTE = 60
) (
    input  logic       Clk_1sec,
    input  logic       reset,
    input  logic       clock_enable,
    input  logic       min_inc,
    input  logic       min_dec,
    input  logic       hour_inc,
    input  logic       hour_dec,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [5:0] hours
`ifdef DIGITAL_CLOCK_AM_PM_EN
    ,
    output logic       pm
`endif
);

    localparam logic [5:0] SEC_LAST = 6'(SECONDS_PER_MINUTE - 1);
    localparam logic [5:0] MIN_LAST = 6'(MINUTES_PER_HOUR - 1);
    localparam logic [5:0] HR_LAST  = 6'(HOURS_PER_DAY - 1);

    // Count up by one, wrapping from last back to zero.
    function automatic logic [5:0] inc_wrap(input logic [5:0] val, input logic [5:0] last);
        return (val == last) ? 6'd0 : val + 6'd1;
    endfunction

    // Count down by one, wrapping from zero back to last.
    function automatic logic [5:0] dec_wrap(input logic [5:0] val, input logic [5:0] last);
        return (val == 6'd0) ? last : val - 6'd1;
    endfunction

    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic [5:0] hr_q,  hr_d;    // always a 0..HOURS_PER_DAY-1 count internally

    logic prev_min_inc_q, prev_min_inc_d;
    logic prev_min_dec_q, prev_min_dec_d;
    logic prev_hour_inc_q, prev_hour_inc_d;
    logic prev_hour_dec_q, prev_hour_dec_d;

    logic press_min_inc, press_min_dec, press_hour_inc, press_hour_dec;
    logic min_up, min_dn, hr_up, hr_dn;

    // Button history and rising-edge detection; history updates in both modes.
    always_comb begin
        prev_min_inc_d  = min_inc;
        prev_min_dec_d  = min_dec;
        prev_hour_inc_d = hour_inc;
        prev_hour_dec_d = hour_dec;
        press_min_inc   = min_inc  & ~prev_min_inc_q;
        press_min_dec   = min_dec  & ~prev_min_dec_q;
        press_hour_inc  = hour_inc & ~prev_hour_inc_q;
        press_hour_dec  = hour_dec & ~prev_hour_dec_q;
        // Opposing presses on the same field in one cycle cancel out.
        min_up = press_min_inc  & ~press_min_dec;
        min_dn = press_min_dec  & ~press_min_inc;
        hr_up  = press_hour_inc & ~press_hour_dec;
        hr_dn  = press_hour_dec & ~press_hour_inc;
    end

    // Next time-of-day: tick with carries in run mode, button steps in set mode.
    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        if (clock_enable) begin
            sec_d = inc_wrap(sec_q, SEC_LAST);
            if (sec_q == SEC_LAST) begin
                min_d = inc_wrap(min_q, MIN_LAST);
                if (min_q == MIN_LAST) begin
                    hr_d = inc_wrap(hr_q, HR_LAST);
                end
            end
        end else begin
            // Minute and hour fields are adjusted independently; no carry between them.
            if (min_up) begin
                min_d = inc_wrap(min_q, MIN_LAST);
            end else if (min_dn) begin
                min_d = dec_wrap(min_q, MIN_LAST);
            end
            if (hr_up) begin
                hr_d = inc_wrap(hr_q, HR_LAST);
            end else if (hr_dn) begin
                hr_d = dec_wrap(hr_q, HR_LAST);
            end
        end
    end

    // Time and button-history registers.
    always_ff @(posedge Clk_1sec or negedge reset) begin
        if (!reset) begin
            sec_q           <= 6'd0;
            min_q           <= 6'd0;
            hr_q            <= 6'd0;
            prev_min_inc_q  <= 1'b0;
            prev_min_dec_q  <= 1'b0;
            prev_hour_inc_q <= 1'b0;
            prev_hour_dec_q <= 1'b0;
        end else begin
            sec_q           <= sec_d;
            min_q           <= min_d;
            hr_q            <= hr_d;
            prev_min_inc_q  <= prev_min_inc_d;
            prev_min_dec_q  <= prev_min_dec_d;
            prev_hour_inc_q <= prev_hour_inc_d;
            prev_hour_dec_q <= prev_hour_dec_d;
        end
    end

    assign seconds = sec_q;
    assign minutes = min_q;

`ifdef DIGITAL_CLOCK_AM_PM_EN
    localparam logic [5:0] HALF_DAY = 6'(HOURS_PER_DAY / 2);

    logic [5:0] disp_hr_q, disp_hr_d;
    logic       pm_q, pm_d;

    // Map the internal day count to 12-hour display: 0 -> 12 AM, HALF_DAY -> 12 PM.
    function automatic logic [5:0] to_12h(input logic [5:0] h);
        logic [5:0] hm;
        hm = (h >= HALF_DAY) ? h - HALF_DAY : h;
        return (hm == 6'd0) ? HALF_DAY : hm;
    endfunction

    // Display hour and AM/PM flag are derived from the next internal count.
    always_comb begin
        disp_hr_d = to_12h(hr_d);
        pm_d      = (hr_d >= HALF_DAY);
    end

    // Display registers so hours/pm stay glitch-free registered outputs.
    always_ff @(posedge Clk_1sec or negedge reset) begin
        if (!reset) begin
            disp_hr_q <= HALF_DAY;
            pm_q      <= 1'b0;
        end else begin
            disp_hr_q <= disp_hr_d;
            pm_q      <= pm_d;
        end
    end

    assign hours = disp_hr_q;
    assign pm    = pm_q;
`else
    assign hours = hr_q;
`endif

endmodule

// File: tb/tb_digital_clock.sv
`timescale 1ns/1ps
module tb_digital_clock;

    localparam int HPD = 24;
    localparam int MPH = 60;
    localparam int SPM = 60;
    localparam int DAY = HPD * MPH * SPM;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce    = 1'b0;
    logic       mi    = 1'b0;
    logic       md    = 1'b0;
    logic       hi    = 1'b0;
    logic       hd    = 1'b0;
    logic [5:0] seconds, minutes, hours;
`ifdef DIGITAL_CLOCK_AM_PM_EN
    logic       pm;
`endif

    digital_clock #(
        .HOURS_PER_DAY(HPD),
        .MINUTES_PER_HOUR(MPH),
        .SECONDS_PER_MINUTE(SPM)
    ) dut (
        .Clk_1sec(clk),
        .reset(rst_n),
        .clock_enable(ce),
        .min_inc(mi),
        .min_dec(md),
        .hour_inc(hi),
        .hour_dec(hd),
        .seconds(seconds),
        .minutes(minutes),
        .hours(hours)
`ifdef DIGITAL_CLOCK_AM_PM_EN
        ,
        .pm(pm)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: time as seconds-of-day plus last-seen button levels.
    int tod = 0;
    bit pv_mi, pv_md, pv_hi, pv_hd;

    typedef struct {
        bit ce, mi, md, hi, hd;
        int es, em, eh;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int disp_h(input int h24);
`ifdef DIGITAL_CLOCK_AM_PM_EN
        int h;
        h = h24 % (HPD / 2);
        return (h == 0) ? HPD / 2 : h;
`else
        return h24;
`endif
    endfunction

    task automatic check_time(input string name, input int s, input int m, input int h24);
        chk({name, ".sec"}, {26'd0, seconds}, s);
        chk({name, ".min"}, {26'd0, minutes}, m);
        chk({name, ".hr"},  {26'd0, hours},   disp_h(h24));
`ifdef DIGITAL_CLOCK_AM_PM_EN
        chk({name, ".pm"},  {31'd0, pm}, (h24 >= HPD / 2) ? 1 : 0);
`endif
    endtask

    task automatic check_model(input string name);
        check_time(name, tod % SPM, (tod / SPM) % MPH, tod / (SPM * MPH));
    endtask

    task automatic model_step(input bit c, input bit a, input bit b, input bit x, input bit y);
        int h, m, s, dm, dh;
        dm = int'(a && !pv_mi) - int'(b && !pv_md);
        dh = int'(x && !pv_hi) - int'(y && !pv_hd);
        pv_mi = a; pv_md = b; pv_hi = x; pv_hd = y;
        if (c) begin
            tod = (tod + 1) % DAY;
        end else begin
            h = tod / (SPM * MPH);
            m = (tod / SPM) % MPH;
            s = tod % SPM;
            m = (m + dm + MPH) % MPH;
            h = (h + dh + HPD) % HPD;
            tod = (h * MPH + m) * SPM + s;
        end
    endtask

    // One Clk_1sec edge with the given inputs; returns 1 time unit after the edge.
    task automatic tick(input bit c, input bit a, input bit b, input bit x, input bit y);
        ce = c; mi = a; md = b; hi = x; hd = y;
        @(posedge clk);
        #1;
        model_step(c, a, b, x, y);
    endtask

    task automatic press_min_inc();  tick(0, 1, 0, 0, 0); tick(0, 0, 0, 0, 0); endtask
    task automatic press_min_dec();  tick(0, 0, 1, 0, 0); tick(0, 0, 0, 0, 0); endtask
    task automatic press_hour_inc(); tick(0, 0, 0, 1, 0); tick(0, 0, 0, 0, 0); endtask
    task automatic press_hour_dec(); tick(0, 0, 0, 0, 1); tick(0, 0, 0, 0, 0); endtask

    // Assert reset between edges, check it acts before any edge, hold through one edge.
    task automatic do_reset(input string name);
        ce = 0; mi = 0; md = 0; hi = 0; hd = 0;
        rst_n = 1'b0;
        #2;
        check_time(name, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tod = 0;
        pv_mi = 0; pv_md = 0; pv_hi = 0; pv_hd = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 1, 0,  0, 23};
        vecs[1]  = '{0, 0, 0, 0, 0, 0,  0, 23};
        vecs[2]  = '{0, 0, 1, 0, 0, 0, 59, 23};
        vecs[3]  = '{0, 0, 1, 0, 0, 0, 59, 23};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 59, 23};
        vecs[5]  = '{0, 1, 1, 0, 0, 0, 59, 23};
        vecs[6]  = '{0, 0, 0, 0, 0, 0, 59, 23};
        vecs[7]  = '{0, 1, 0, 1, 0, 0,  0,  0};
        vecs[8]  = '{1, 0, 0, 0, 0, 1,  0,  0};
        vecs[9]  = '{1, 0, 0, 1, 0, 2,  0,  0};
        vecs[10] = '{0, 0, 0, 1, 0, 2,  0,  0};
        vecs[11] = '{0, 0, 0, 0, 0, 2,  0,  0};
        vecs[12] = '{0, 0, 0, 1, 1, 2,  0,  0};
        vecs[13] = '{1, 0, 0, 0, 0, 3,  0,  0};

        #1;
        // Reset, then set mode with idle buttons: time stays at zero.
        do_reset("reset");
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0, 0, 0);
            check_time("idle_set", 0, 0, 0);
        end

        // Run mode carries.
        for (int i = 0; i < 61; i++) tick(1, 0, 0, 0, 0);
        check_time("run61", 1, 1, 0);
        for (int i = 0; i < 3599; i++) tick(1, 0, 0, 0, 0);
        check_time("run3660", 0, 1, 1);
        check_model("run3660_model");

        // Full-day wrap from 23:59:58.
        do_reset("reset2");
        for (int i = 0; i < 58; i++) tick(1, 0, 0, 0, 0);
        press_hour_dec();
        check_time("hour_dec_wrap", 58, 0, 23);
        press_min_dec();
        check_time("min_dec_noborrow", 58, 59, 23);
        tick(1, 0, 0, 0, 0);
        check_time("wrap1", 59, 59, 23);
        tick(1, 0, 0, 0, 0);
        check_time("day_wrap", 0, 0, 0);

        // Held min_inc steps once per rising edge; 60 presses wrap minutes only.
        for (int k = 0; k < 60; k++) begin
            for (int j = 0; j < 5; j++) tick(0, 1, 0, 0, 0);
            check_time("min_hold", 0, (k + 1) % 60, 0);
            for (int j = 0; j < 5; j++) tick(0, 0, 0, 0, 0);
        end
        check_model("min_hold_model");

        // Vector table: wraps, held levels, cancellation, simultaneous fields, run-mode presses.
        do_reset("reset3");
        foreach (vecs[i]) begin
            tick(vecs[i].ce, vecs[i].mi, vecs[i].md, vecs[i].hi, vecs[i].hd);
            check_time($sformatf("vec%0d", i), vecs[i].es, vecs[i].em, vecs[i].eh);
        end
        check_model("vec_model");

        // Set 12:34:56, then async reset between edges.
        do_reset("reset4");
        for (int i = 0; i < 56; i++) tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) press_hour_inc();
        for (int i = 0; i < 34; i++) press_min_inc();
        check_time("set_123456", 56, 34, 12);
        check_model("set_123456_model");
        do_reset("async_reset");
        tick(1, 0, 0, 1, 0);
        check_time("run_hour_press", 1, 0, 0);
        tick(0, 0, 0, 1, 0);
        check_time("consumed_press", 1, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
